// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode-0 constants and counter sizing for spi_master_tx.
package spi_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_e;

   // {CPOL, CPHA}: sclk idles low, data launched on falling edge, sampled on rising edge
   localparam logic [1:0] SPI_MODE0 = 2'b00;

   function automatic int cnt_width(input int div);
      return $clog2(div + 1);
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period counter; phase_end marks the last clk cycle of each sclk half-period.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic phase_end
);

   localparam int CW = cnt_width(CLK_DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      phase_end = en && (cnt_q == CW'(CLK_DIV - 1));
      cnt_d     = (!en || phase_end) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;

endmodule

// File: rtl/spi_master_tx.sv
// spi_master_tx: mode-0 SPI initiator, one WIDTH-bit word per cs_n frame with miso capture.
// Define SPI_LSB_FIRST_EN to shift both directions LSB-first; default is MSB-first.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int BW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, tx_shift, rx_shift;
   logic [BW-1:0]    bit_q, bit_d;
   logic             rx_valid_q, busy, phase_end, accept, rise, fall, last, tx_bit;

`ifdef SPI_LSB_FIRST_EN
   assign tx_shift = {1'b0, tx_sh_q[WIDTH-1:1]};
   assign rx_shift = {miso, rx_sh_q[WIDTH-1:1]};
   assign tx_bit   = tx_sh_q[0];
`else
   assign tx_shift = {tx_sh_q[WIDTH-2:0], 1'b0};
   assign rx_shift = {rx_sh_q[WIDTH-2:0], miso};
   assign tx_bit   = tx_sh_q[WIDTH-1];
`endif

   spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (busy),
      .phase_end(phase_end)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         bit_q      <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         bit_q      <= bit_d;
         rx_data_q  <= (state_q == DONE) ? rx_sh_q : rx_data_q;
         rx_valid_q <= (state_q == DONE);
      end

   // bit_q wraps to 0 on the WIDTH-th rise, so a zero count while HIGH means the word is complete
   always_comb begin
      busy    = state_q inside {SETUP, HIGH, LOW};
      accept  = tx_valid && tx_ready;
      rise    = phase_end && (state_q inside {SETUP, LOW});
      fall    = phase_end && (state_q == HIGH);
      last    = (bit_q == '0);
      state_d = accept ? SETUP :
                rise   ? HIGH  :
                fall   ? (last ? DONE : LOW) :
                (state_q == DONE) ? IDLE : state_q;
      tx_sh_d = accept ? tx_data : (fall && !last) ? tx_shift : tx_sh_q;
      rx_sh_d = rise ? rx_shift : rx_sh_q;
      bit_d   = accept ? '0 :
                rise   ? ((bit_q == BW'(WIDTH - 1)) ? '0 : bit_q + 1'b1) : bit_q;
   end

   // tx_ready is held off while rx_valid pulses so results are seen before the next request
   always_comb begin
      tx_ready = (state_q == IDLE) && !rx_valid_q;
      cs_n     = !busy;
      sclk     = (state_q == HIGH) ^ SPI_MODE0[1];
      mosi     = busy && tx_bit;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb_spi_master_tx: directed checks of framing, latency, loopback capture, back-to-back and reset abort.
module tb_spi_master_tx;

   logic       clk, rst_n, tx_valid, tx_ready, rx_valid, sclk, cs_n, mosi, miso;
   logic       loop, miso_fix;
   logic [7:0] tx_data, rx_data, mosi_log;
   int         errors = 0, checks = 0;
   int         rises = 0, rxv_cnt = 0, idle_viol = 0, mosi_hi = 0;

   assign miso = loop ? mosi : miso_fix;

   spi_master_tx #(.WIDTH(8), .CLK_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_data (tx_data),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .sclk    (sclk),
      .cs_n    (cs_n),
      .mosi    (mosi),
      .miso    (miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge sclk) if (!cs_n) begin
      mosi_log = {mosi_log[6:0], mosi};
      rises    = rises + 1;
   end

   always @(posedge clk) if (rx_valid) rxv_cnt = rxv_cnt + 1;

   always @(negedge clk) begin
      if (cs_n && sclk) idle_viol = idle_viol + 1;
      if (!cs_n && mosi) mosi_hi = mosi_hi + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns cycles from the accepting edge to the rx_valid pulse, sampled 1 time unit after each edge
   task automatic send(input logic [7:0] d, output int lat);
      int n;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~d;
      lat = 0;
      while (!rx_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      int lat, r0, v0, m0, n, gap;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; loop = 1'b1; miso_fix = 1'b0; mosi_log = 8'h00;
      #22;
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_ready", tx_ready, 1);
      check("rst_rxv", rx_valid, 0);
      check("rst_rxdata", rx_data, 8'h00);
      check("rst_mosi", mosi, 0);
      @(negedge clk) rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!cs_n || sclk || !tx_ready || rx_valid) n++;
      end
      check("idle_20", n, 0);

      r0 = rises; v0 = rxv_cnt;
      send(8'b01001111, lat);
      check("lb_latency", lat, 65);
      check("lb_rxdata", rx_data, 8'h4F);
      check("lb_mosi_seq", mosi_log, 8'h4F);
      check("lb_rises", rises - r0, 8);
      check("lb_ready_during_rxv", tx_ready, 0);
      @(posedge clk); #1;
      check("lb_ready_after", tx_ready, 1);
      check("lb_rxv_pulse_end", rx_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      check("lb_rxv_count", rxv_cnt - v0, 1);

      loop = 1'b0; miso_fix = 1'b1;
      r0 = rises; m0 = mosi_hi;
      send(8'h00, lat);
      check("ones_rxdata", rx_data, 8'hFF);
      check("ones_mosi_seq", mosi_log, 8'h00);
      check("ones_mosi_high", mosi_hi - m0, 0);
      check("ones_rises", rises - r0, 8);
      check("ones_latency", lat, 65);

      loop = 1'b1;
      @(negedge clk);
      tx_valid = 1'b1; tx_data = 8'hA5;
      n = 0;
      while (cs_n && n < 200) begin @(negedge clk); n++; end
      tx_data = 8'h3C;
      n = 0;
      while (!cs_n && n < 200) begin @(negedge clk); n++; end
      gap = 0;
      while (cs_n && gap < 200) begin @(negedge clk); gap++; end
      tx_valid = 1'b0;
      check("b2b_first_rx", rx_data, 8'hA5);
      check("b2b_gap_ge2", gap >= 2, 1);
      n = 0;
      while (!rx_valid && n < 200) begin @(negedge clk); n++; end
      check("b2b_second_rx", rx_data, 8'h3C);

      repeat (3) @(negedge clk);
      r0 = rises;
      tx_valid = 1'b1; tx_data = 8'h5A;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      n = 0;
      while (rises - r0 < 3 && n < 200) begin @(negedge clk); n++; end
      check("abort_rise3", rises - r0, 3);
      v0 = rxv_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("abort_cs_n", cs_n, 1);
      check("abort_sclk", sclk, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      check("abort_no_rxv", rxv_cnt - v0, 0);
      check("abort_rxdata", rx_data, 8'h00);
      send(8'h81, lat);
      check("post_rst_latency", lat, 65);
      check("post_rst_rx", rx_data, 8'h81);

      send(8'h01, lat);
`ifdef SPI_LSB_FIRST_EN
      check("order_first_bit", mosi_log[7], 1);
`else
      check("order_first_bit", mosi_log[7], 0);
`endif
      check("order_rx", rx_data, 8'h01);
      check("sclk_idle_viol", idle_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
